// File: rtl/key_pkg.sv
`default_nettype none
// key_pkg: shared FSM state type and default timing for the key_event pushbutton block.
package key_pkg;

   typedef enum logic [0:0] {
      RELEASED = 1'b0,
      PRESSED  = 1'b1
   } key_state_t;

   // 20 ms debounce and 1 s long-press threshold at 50 MHz
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
   localparam int DEFAULT_LONG_CYCLES     = 50000000;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// key_debounce: two-flop synchronizer plus stable-run counter; level follows key_n polarity
// (1 = released) and change pulses in the cycle whose edge flips level.
module key_debounce
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_n,
   output logic level,
   output logic change
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;

   // change is combinational so the FSM in the parent acts on the same edge that updates level
   assign change = (s2 != level) && (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1    <= 1'b1;
         s2    <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
      end else begin
         s1 <= key_n;
         s2 <= s1;
         if (s2 == level) begin
            cnt <= '0;
         end else if (change) begin
            level <= s2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_ONE;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/key_event.sv
`default_nettype none
// key_event: debounced pushbutton that classifies each press as short or long and
// presents it as a single-entry event with sticky overflow.
module key_event
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
   input  logic CLOCK_50,
   input  logic reset_n,
   input  logic key_n,
   input  logic read,
   output logic valid,
   output logic long,
   output logic held,
   output logic overflow
);

   localparam int HW = $clog2(LONG_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
   localparam logic [HW-1:0] HOLD_ONE = HW'(1);

   logic          level;
   logic          change;
   key_state_t    state;
   logic [HW-1:0] hold_cnt;
   logic          release_ev;
   logic          ev_long;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk     (CLOCK_50),
      .reset_n (reset_n),
      .key_n   (key_n),
      .level   (level),
      .change  (change)
   );

   // level is a flop, so held is a clean registered signal
   assign held       = ~level;
   assign release_ev = change && (state == PRESSED);
   assign ev_long    = (hold_cnt == HOLD_MAX);

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         state    <= RELEASED;
         hold_cnt <= '0;
      end else begin
         case (state)
            RELEASED: begin
               if (change) begin
                  state    <= PRESSED;
                  hold_cnt <= '0;
               end
            end
            PRESSED: begin
               if (change) begin
                  state <= RELEASED;
               end else if (hold_cnt != HOLD_MAX) begin
                  hold_cnt <= hold_cnt + HOLD_ONE;
               end
            end
            default: begin
               state    <= RELEASED;
               hold_cnt <= '0;
            end
         endcase
      end
   end

   // Single-entry event slot; a read in the same cycle frees the slot for the new event
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         valid    <= 1'b0;
         long     <= 1'b0;
         overflow <= 1'b0;
      end else if (release_ev) begin
         if (!valid || read) begin
            valid <= 1'b1;
            long  <= ev_long;
         end else begin
            overflow <= 1'b1;
         end
      end else if (valid && read) begin
         valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_key_event.sv
`default_nettype none
// tb_key_event: directed self-checking bench for key_event with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
module tb_key_event;

   logic CLOCK_50 = 1'b0;
   logic reset_n;
   logic key_n;
   logic read;
   logic valid;
   logic long;
   logic held;
   logic overflow;

   int errors = 0;
   int checks = 0;

   key_event #(
      .DEBOUNCE_CYCLES (4),
      .LONG_CYCLES     (10)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .key_n    (key_n),
      .read     (read),
      .valid    (valid),
      .long     (long),
      .held     (held),
      .overflow (overflow)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Advance n rising edges, then settle 1 time unit past the edge
   task automatic tick(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Press for n cycles, release, and wait until the release has produced its event
   task automatic press(input int n);
      key_n = 1'b0;
      tick(n);
      key_n = 1'b1;
      tick(8);
   endtask

   task automatic read_pulse();
      read = 1'b1;
      tick(1);
      read = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      key_n   = 1'b0;
      read    = 1'b0;

      // Reset with key held down
      tick(2);
      chk("rst_valid", valid, 1'b0);
      chk("rst_long", long, 1'b0);
      chk("rst_held", held, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      reset_n = 1'b1;
      tick(5);
      chk("rst_held_edge5", held, 1'b0);
      tick(1);
      chk("rst_held_edge6", held, 1'b1);
      key_n = 1'b1;
      tick(6);
      chk("rst_rel_valid", valid, 1'b1);
      chk("rst_rel_long", long, 1'b0);
      chk("rst_rel_held", held, 1'b0);
      read_pulse();
      chk("rst_read_clear", valid, 1'b0);

      // Bounce: toggle every 2 cycles for 16 cycles, then stay released
      for (int i = 0; i < 8; i++) begin
         key_n = ~key_n;
         tick(2);
         chk("bounce_held", held, 1'b0);
         chk("bounce_valid", valid, 1'b0);
      end
      tick(8);
      chk("bounce_end_held", held, 1'b0);
      chk("bounce_end_valid", valid, 1'b0);

      // Short press of 8 cycles
      key_n = 1'b0;
      tick(5);
      chk("short_held_early", held, 1'b0);
      tick(1);
      chk("short_held_rise", held, 1'b1);
      tick(2);
      key_n = 1'b1;
      tick(5);
      chk("short_held_late", held, 1'b1);
      chk("short_valid_early", valid, 1'b0);
      tick(1);
      chk("short_held_fall", held, 1'b0);
      chk("short_valid", valid, 1'b1);
      chk("short_long", long, 1'b0);
      tick(3);
      chk("short_valid_hold", valid, 1'b1);
      chk("short_long_hold", long, 1'b0);
      read_pulse();
      chk("short_read_clear", valid, 1'b0);
      read = 1'b1;
      tick(2);
      read = 1'b0;
      chk("idle_read_valid", valid, 1'b0);
      chk("idle_read_overflow", overflow, 1'b0);

      // Long press of 30 cycles
      key_n = 1'b0;
      tick(30);
      key_n = 1'b1;
      tick(6);
      chk("long_valid", valid, 1'b1);
      chk("long_long", long, 1'b1);
      read_pulse();
      chk("long_read_clear", valid, 1'b0);

      // Overflow: two short presses without read
      press(8);
      chk("ovf1_valid", valid, 1'b1);
      chk("ovf1_overflow", overflow, 1'b0);
      press(8);
      chk("ovf2_valid", valid, 1'b1);
      chk("ovf2_long", long, 1'b0);
      chk("ovf2_overflow", overflow, 1'b1);
      read_pulse();
      chk("ovf_read_valid", valid, 1'b0);
      chk("ovf_read_overflow", overflow, 1'b1);

      // Overflow: pending long event must survive a dropped short one
      press(30);
      chk("ovf3_long", long, 1'b1);
      press(8);
      chk("ovf4_valid", valid, 1'b1);
      chk("ovf4_long", long, 1'b1);
      chk("ovf4_overflow", overflow, 1'b1);

      // Reset discards the pending event and overflow
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      chk("rst2_valid", valid, 1'b0);
      chk("rst2_overflow", overflow, 1'b0);
      chk("rst2_long", long, 1'b0);

      // Coincidence: read accepted on the edge the second event is generated
      press(8);
      chk("coin1_valid", valid, 1'b1);
      chk("coin1_long", long, 1'b0);
      key_n = 1'b0;
      tick(30);
      key_n = 1'b1;
      tick(5);
      chk("coin_pre_long", long, 1'b0);
      read = 1'b1;
      tick(1);
      read = 1'b0;
      chk("coin_valid", valid, 1'b1);
      chk("coin_long", long, 1'b1);
      chk("coin_overflow", overflow, 1'b0);
      tick(1);
      chk("coin_valid_next", valid, 1'b1);
      chk("coin_long_next", long, 1'b1);
      read_pulse();
      chk("coin_read_clear", valid, 1'b0);
      chk("coin_overflow_end", overflow, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
